aes128_round_seq: RTL and testbench

- Sequencer for the iterative AES-128 round datapath inside the TinyQV peripheral.
- Decodes the peripheral register bus: key and plaintext words are forwarded to the datapath, START launches the run, STATUS and result reads come back on the bus.
- Issues the load, round and final-round steps with the matching round constant over a valid/ready handshake.
- Raises `user_interrupt` on completion.

---
 rtl/aes128_pkg.sv | 40 ++++
 rtl/aes128_round_seq.sv | 211 +++++++++++++++++++++
 tb/tb_aes128_round_seq.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes128_pkg.sv
// Shared definitions for the AES-128 round sequencer: the register map,
// the CTRL/STATUS bit positions, the FSM state encoding and the GF(2^8)
// doubling used to step the round constant.
package aes128_pkg;

  // Byte addresses of the peripheral registers. KEY, BLK and RES are each a
  // bank of four words, selected by address[3:2].
  localparam logic [5:0] ADDR_KEY0   = 6'h00;
  localparam logic [5:0] ADDR_BLK0   = 6'h10;
  localparam logic [5:0] ADDR_CTRL   = 6'h20;
  localparam logic [5:0] ADDR_STATUS = 6'h24;
  localparam logic [5:0] ADDR_RES0   = 6'h30;

  // CTRL bit positions.
  localparam int CTRL_START   = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_IRQ_CLR = 2;

  // STATUS bit positions. The round number occupies bits [7:4].
  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_IRQ       = 2;
  localparam int STAT_ERR       = 3;
  localparam int STAT_ROUND_LSB = 4;

  // Round constant used by round 1. Later rounds double it in GF(2^8).
  localparam logic [7:0] RCON_FIRST = 8'h01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2
  } state_t;

  // Multiply by x in GF(2^8) modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/aes128_round_seq.sv
// Sequencer for the iterative AES-128 round datapath. Decodes the TinyQV
// peripheral bus, forwards key/block words to the datapath, steps the
// datapath through load + ROUNDS rounds with the matching round constant,
// and reports status, results and a completion interrupt.
module aes128_round_seq
  import aes128_pkg::*;
#(
  parameter int ROUNDS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt,
  output logic        dp_wr,
  output logic        dp_wsel,
  output logic [1:0]  dp_widx,
  output logic [31:0] dp_wdata,
  output logic        dp_valid,
  output logic        dp_load,
  output logic        dp_final,
  output logic [3:0]  dp_round,
  output logic [7:0]  dp_rcon,
  input  logic        dp_ready,
  output logic [1:0]  dp_ridx,
  input  logic [31:0] dp_rdata
);

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_round;
  logic [7:0]  r_rcon;
  logic        r_done;
  logic        r_err;
  logic        r_irq_pending;
  logic        r_irq_en;
  logic        r_dp_wr;
  logic        r_dp_wsel;
  logic [1:0]  r_dp_widx;
  logic [31:0] r_dp_wdata;
  logic [31:0] r_data_out;
  logic        r_data_ready;

  logic        w_aligned;
  logic        w_wr;
  logic        w_rd;
  logic        w_hit_key;
  logic        w_hit_blk;
  logic        w_hit_ctrl;
  logic        w_hit_status;
  logic        w_hit_res;
  logic        w_busy;
  logic        w_step;
  logic        w_last;
  logic        w_finish;
  logic        w_start;
  logic        w_irq_clr;
  logic        w_word_wr;
  logic        w_rd_accept;
  logic [31:0] w_rd_data;

  // Bus decode. Only word-aligned addresses hit a register.
  assign w_aligned    = (address[1:0] == 2'b00);
  assign w_wr         = (data_write_n == 2'b10);
  assign w_rd         = (data_read_n != 2'b11);
  assign w_hit_key    = w_aligned && (address[5:4] == ADDR_KEY0[5:4]);
  assign w_hit_blk    = w_aligned && (address[5:4] == ADDR_BLK0[5:4]);
  assign w_hit_ctrl   = (address == ADDR_CTRL);
  assign w_hit_status = (address == ADDR_STATUS);
  assign w_hit_res    = w_aligned && (address[5:4] == ADDR_RES0[5:4]);

  assign w_busy    = (r_state != S_IDLE);
  assign w_step    = w_busy && dp_ready;
  assign w_last    = (r_state == S_ROUND) && (r_round == LAST_ROUND);
  assign w_finish  = w_step && w_last;
  assign w_start   = w_wr && w_hit_ctrl && data_in[CTRL_START] && !w_busy;
  assign w_irq_clr = w_wr && w_hit_ctrl && data_in[CTRL_IRQ_CLR];
  assign w_word_wr = w_wr && (w_hit_key || w_hit_blk);

  // A result read stalls while a run is in flight so it never returns a
  // half-processed state; a read is not re-accepted in its own ready cycle.
  assign w_rd_accept = w_rd && !r_data_ready && !(w_hit_res && w_busy);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic: one load step, then rounds until the last is accepted.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start)            w_state_next = S_LOAD;
      S_LOAD:  if (dp_ready)           w_state_next = S_ROUND;
      S_ROUND: if (dp_ready && w_last) w_state_next = S_IDLE;
      default:                         w_state_next = S_IDLE;
    endcase
  end

  // Round counter and round constant; both only move on an accepted step,
  // which keeps them stable while a request is waiting for dp_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_round <= 4'd0;
      r_rcon  <= 8'h00;
    end else if (w_start) begin
      r_round <= 4'd0;
      r_rcon  <= 8'h00;
    end else if (w_step) begin
      if (r_state == S_LOAD) begin
        r_round <= 4'd1;
        r_rcon  <= RCON_FIRST;
      end else if (!w_last) begin
        r_round <= r_round + 4'd1;
        r_rcon  <= xtime(r_rcon);
      end
    end
  end

  // Status flags, interrupt enable and the pending interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_irq_en      <= 1'b0;
      r_irq_pending <= 1'b0;
    end else begin
      if (w_start) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end
      if (w_finish)             r_done   <= 1'b1;
      if (w_word_wr && w_busy)  r_err    <= 1'b1;
      if (w_wr && w_hit_ctrl)   r_irq_en <= data_in[CTRL_IRQ_EN];
      // NOTE: non-blocking assignments to the same register resolve to the
      // last one executed, so the completion set below wins over a clear
      // arriving in the same cycle.
      if (w_start || w_irq_clr) r_irq_pending <= 1'b0;
      if (w_finish && r_irq_en) r_irq_pending <= 1'b1;
    end
  end

  // Key/block word forwarding: a one-cycle write pulse, suppressed mid-run
  // so the datapath never sees its operands change under it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dp_wr    <= 1'b0;
      r_dp_wsel  <= 1'b0;
      r_dp_widx  <= 2'd0;
      r_dp_wdata <= 32'd0;
    end else begin
      r_dp_wr <= w_word_wr && !w_busy;
      if (w_word_wr && !w_busy) begin
        r_dp_wsel  <= w_hit_blk;
        r_dp_widx  <= address[3:2];
        r_dp_wdata <= data_in;
      end
    end
  end

  // Read data multiplexer; unmapped and write-only registers read as zero.
  always_comb begin
    w_rd_data = 32'd0;
    if (w_hit_ctrl) begin
      w_rd_data[CTRL_IRQ_EN] = r_irq_en;
    end else if (w_hit_status) begin
      w_rd_data[STAT_BUSY]               = w_busy;
      w_rd_data[STAT_DONE]               = r_done;
      w_rd_data[STAT_IRQ]                = r_irq_pending;
      w_rd_data[STAT_ERR]                = r_err;
      w_rd_data[STAT_ROUND_LSB +: 4]     = r_round;
    end else if (w_hit_res) begin
      w_rd_data = dp_rdata;
    end
  end

  // Registered read response: one ready pulse per accepted read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out   <= 32'd0;
      r_data_ready <= 1'b0;
    end else begin
      r_data_ready <= w_rd_accept;
      if (w_rd_accept) r_data_out <= w_rd_data;
    end
  end

  assign data_out       = r_data_out;
  assign data_ready     = r_data_ready;
  assign user_interrupt = r_irq_pending;
  assign dp_wr          = r_dp_wr;
  assign dp_wsel        = r_dp_wsel;
  assign dp_widx        = r_dp_widx;
  assign dp_wdata       = r_dp_wdata;
  assign dp_valid       = w_busy;
  assign dp_load        = (r_state == S_LOAD);
  assign dp_final       = w_last;
  assign dp_round       = r_round;
  assign dp_rcon        = r_rcon;
  assign dp_ridx        = (w_rd && w_hit_res) ? address[3:2] : 2'd0;

endmodule

// File: tb/tb_aes128_round_seq.sv
// Directed testbench for aes128_round_seq: bus decode, round sequencing,
// handshake stalls, stalled result reads, busy-write errors, interrupt
// set/clear priority and mid-run reset.
module tb_aes128_round_seq;

  localparam logic [5:0] A_KEY0   = 6'h00;
  localparam logic [5:0] A_KEY2   = 6'h08;
  localparam logic [5:0] A_CTRL   = 6'h20;
  localparam logic [5:0] A_STATUS = 6'h24;
  localparam logic [5:0] A_RES1   = 6'h34;
  localparam logic [5:0] A_UNMAP  = 6'h28;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;
  logic        dp_wr;
  logic        dp_wsel;
  logic [1:0]  dp_widx;
  logic [31:0] dp_wdata;
  logic        dp_valid;
  logic        dp_load;
  logic        dp_final;
  logic [3:0]  dp_round;
  logic [7:0]  dp_rcon;
  logic        dp_ready;
  logic [1:0]  dp_ridx;
  logic [31:0] dp_rdata;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  rcon_exp [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
  logic [31:0] words [8] = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F,
                             32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};

  // Stand-in datapath result: a recognisable tag plus the selected index.
  assign dp_rdata = 32'h5EED_0000 | {30'd0, dp_ridx};

  always #5 clk = ~clk;

  aes128_round_seq #(.ROUNDS(10)) dut (
    .clk            (clk),
    .rst            (rst),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt),
    .dp_wr          (dp_wr),
    .dp_wsel        (dp_wsel),
    .dp_widx        (dp_widx),
    .dp_wdata       (dp_wdata),
    .dp_valid       (dp_valid),
    .dp_load        (dp_load),
    .dp_final       (dp_final),
    .dp_round       (dp_round),
    .dp_rcon        (dp_rcon),
    .dp_ready       (dp_ready),
    .dp_ridx        (dp_ridx),
    .dp_rdata       (dp_rdata)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 32-bit write held for one cycle; returns in the cycle after the write.
  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    address      = a;
    data_in      = d;
    data_write_n = 2'b10;
    tick();
    data_write_n = 2'b11;
  endtask

  // Single-cycle read strobe; returns data_out/data_ready of the next cycle.
  task automatic bus_read(input logic [5:0] a, output logic [31:0] d, output logic rdy);
    address     = a;
    data_read_n = 2'b00;
    tick();
    d           = data_out;
    rdy         = data_ready;
    data_read_n = 2'b11;
  endtask

  // Tick until user_interrupt rises, with a bounded budget.
  task automatic wait_irq(input int start, output int cnt);
    cnt = start;
    while (!user_interrupt && cnt < start + 40) begin
      tick();
      cnt++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        rdy;
    checks++;
    if ({data_out, data_ready, user_interrupt, dp_wr, dp_wsel, dp_valid, dp_load, dp_final,
         dp_round, dp_widx, dp_wdata, dp_rcon, dp_ridx} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got out=%h rdy=%b irq=%b wr=%b valid=%b load=%b final=%b round=%h rcon=%h wdata=%h, expected all zero",
               data_out, data_ready, user_interrupt, dp_wr, dp_valid, dp_load, dp_final, dp_round, dp_rcon, dp_wdata);
    end
    bus_read(A_STATUS, d, rdy);
    checks++;
    if ({rdy, d} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL reset_status: got rdy=%b data=%h, expected rdy=1 data=00000000", rdy, d);
    end
  endtask

  task automatic test_word_write();
    logic [36:0] exp;
    for (int i = 0; i < 8; i++) begin
      bus_write(6'(i * 4), words[i]);
      exp = {1'b1, (i >= 4), 2'(i % 4), words[i]};
      checks++;
      if ({dp_wr, dp_wsel, dp_widx, dp_wdata} !== exp) begin
        failures++;
        $display("FAIL word_write%0d: got wr/sel/idx/data=%h, expected %h", i,
                 {dp_wr, dp_wsel, dp_widx, dp_wdata}, exp);
      end
    end
    tick();
    checks++;
    if (dp_wr !== 1'b0) begin
      failures++;
      $display("FAIL word_write_pulse: got dp_wr=%b, expected 0", dp_wr);
    end
    // A 01 strobe and an unmapped address must both be ignored.
    address = A_KEY0; data_in = 32'h1234_5678; data_write_n = 2'b01;
    tick();
    data_write_n = 2'b11;
    bus_write(A_UNMAP, 32'hFFFF_FFFF);
    checks++;
    if (dp_wr !== 1'b0 || dp_valid !== 1'b0) begin
      failures++;
      $display("FAIL ignored_writes: got dp_wr=%b dp_valid=%b, expected 0 0", dp_wr, dp_valid);
    end
  endtask

  task automatic test_full_run();
    logic [31:0] d;
    logic        rdy;
    logic [14:0] exp;
    bus_write(A_CTRL, 32'h2);
    bus_write(A_CTRL, 32'h3);
    checks++;
    if ({dp_valid, dp_load, dp_final, dp_round} !== {1'b1, 1'b1, 1'b0, 4'd0}) begin
      failures++;
      $display("FAIL run_load: got valid=%b load=%b final=%b round=%0d, expected 1 1 0 0",
               dp_valid, dp_load, dp_final, dp_round);
    end
    for (int r = 1; r <= 10; r++) begin
      tick();
      exp = {1'b1, 1'b0, (r == 10), 4'(r), rcon_exp[r-1]};
      checks++;
      if ({dp_valid, dp_load, dp_final, dp_round, dp_rcon} !== exp) begin
        failures++;
        $display("FAIL run_round%0d: got valid/load/final/round/rcon=%h, expected %h", r,
                 {dp_valid, dp_load, dp_final, dp_round, dp_rcon}, exp);
      end
    end
    checks++;
    if (user_interrupt !== 1'b0) begin
      failures++;
      $display("FAIL run_irq_early: got irq=%b at T+11, expected 0", user_interrupt);
    end
    tick();
    checks++;
    if ({dp_valid, user_interrupt} !== 2'b01) begin
      failures++;
      $display("FAIL run_done: got valid=%b irq=%b at T+12, expected 0 1", dp_valid, user_interrupt);
    end
    bus_read(A_STATUS, d, rdy);
    checks++;
    if ({rdy, d} !== {1'b1, 32'hA6}) begin
      failures++;
      $display("FAIL run_status: got rdy=%b data=%h, expected rdy=1 data=000000a6", rdy, d);
    end
  endtask

  task automatic test_ready_stall();
    int cnt;
    bus_write(A_CTRL, 32'h3);
    repeat (4) tick();
    dp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({dp_valid, dp_load, dp_final, dp_round, dp_rcon} !== {3'b100, 4'd4, 8'h08}) begin
        failures++;
        $display("FAIL stall_hold%0d: got valid=%b load=%b final=%b round=%0d rcon=%h, expected 1 0 0 4 08",
                 k, dp_valid, dp_load, dp_final, dp_round, dp_rcon);
      end
      tick();
    end
    dp_ready = 1'b1;
    checks++;
    if ({dp_valid, dp_round, dp_rcon} !== {1'b1, 4'd4, 8'h08}) begin
      failures++;
      $display("FAIL stall_release: got valid=%b round=%0d rcon=%h, expected 1 4 08", dp_valid, dp_round, dp_rcon);
    end
    wait_irq(8, cnt);
    checks++;
    if (cnt !== 15) begin
      failures++;
      $display("FAIL stall_latency: got completion at T+%0d, expected T+15", cnt);
    end
  endtask

  task automatic test_res_read_stall();
    int cnt;
    bus_write(A_CTRL, 32'h3);
    repeat (2) tick();
    address     = A_RES1;
    data_read_n = 2'b00;
    cnt = 3;
    while (data_ready !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    data_read_n = 2'b11;
    checks++;
    if (cnt !== 13) begin
      failures++;
      $display("FAIL res_stall_latency: got data_ready at T+%0d, expected T+13", cnt);
    end
    checks++;
    if (data_out !== 32'h5EED_0001) begin
      failures++;
      $display("FAIL res_stall_data: got %h, expected 5eed0001", data_out);
    end
    tick();
    checks++;
    if (data_ready !== 1'b0) begin
      failures++;
      $display("FAIL res_ready_pulse: got data_ready=%b, expected 0", data_ready);
    end
  endtask

  task automatic test_busy_writes();
    logic [31:0] d;
    logic        rdy;
    int          cnt;
    bus_write(A_CTRL, 32'h3);
    repeat (2) tick();
    bus_write(A_KEY2, 32'hDEAD_BEEF);
    checks++;
    if (dp_wr !== 1'b0) begin
      failures++;
      $display("FAIL busy_key_forward: got dp_wr=%b, expected 0", dp_wr);
    end
    bus_write(A_CTRL, 32'h3);
    bus_read(A_STATUS, d, rdy);
    checks++;
    if ({rdy, d} !== {1'b1, 32'h49}) begin
      failures++;
      $display("FAIL busy_status: got rdy=%b data=%h, expected rdy=1 data=00000049", rdy, d);
    end
    wait_irq(6, cnt);
    checks++;
    if (cnt !== 12) begin
      failures++;
      $display("FAIL busy_run_latency: got completion at T+%0d, expected T+12", cnt);
    end
    bus_read(A_STATUS, d, rdy);
    checks++;
    if (d !== 32'hAE) begin
      failures++;
      $display("FAIL busy_err_sticky: got %h, expected 000000ae", d);
    end
    bus_write(A_CTRL, 32'h3);
    bus_read(A_STATUS, d, rdy);
    checks++;
    if (d !== 32'h01) begin
      failures++;
      $display("FAIL start_clears_err: got %h, expected 00000001", d);
    end
    wait_irq(2, cnt);
    checks++;
    if (cnt !== 12) begin
      failures++;
      $display("FAIL rerun_latency: got completion at T+%0d, expected T+12", cnt);
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    logic        rdy;
    int          cnt;
    bus_write(A_CTRL, 32'h3);
    repeat (10) tick();
    bus_write(A_CTRL, 32'h6);
    checks++;
    if (user_interrupt !== 1'b1) begin
      failures++;
      $display("FAIL irq_set_wins: got irq=%b, expected 1", user_interrupt);
    end
    bus_write(A_CTRL, 32'h0);
    checks++;
    if (user_interrupt !== 1'b1) begin
      failures++;
      $display("FAIL irq_en_clear_keeps: got irq=%b, expected 1", user_interrupt);
    end
    bus_write(A_CTRL, 32'h4);
    checks++;
    if (user_interrupt !== 1'b0) begin
      failures++;
      $display("FAIL irq_clr: got irq=%b, expected 0", user_interrupt);
    end
    bus_read(A_CTRL, d, rdy);
    checks++;
    if ({rdy, d} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL ctrl_readback: got rdy=%b data=%h, expected rdy=1 data=00000000", rdy, d);
    end
    bus_write(A_CTRL, 32'h3);
    wait_irq(1, cnt);
    bus_write(A_CTRL, 32'h7);
    checks++;
    if ({user_interrupt, dp_load, dp_valid} !== 3'b011) begin
      failures++;
      $display("FAIL start_with_clr: got irq=%b load=%b valid=%b, expected 0 1 1",
               user_interrupt, dp_load, dp_valid);
    end
    wait_irq(1, cnt);
  endtask

  task automatic test_rst_mid_run();
    logic [31:0] d;
    logic        rdy;
    int          cnt;
    bus_write(A_CTRL, 32'h3);
    repeat (5) tick();
    checks++;
    if (dp_round !== 4'd5) begin
      failures++;
      $display("FAIL rst_pre_round: got round=%0d, expected 5", dp_round);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({dp_valid, dp_load, dp_final, dp_round, dp_rcon, user_interrupt} !== '0) begin
      failures++;
      $display("FAIL rst_outputs: got valid=%b load=%b final=%b round=%0d rcon=%h irq=%b, expected all zero",
               dp_valid, dp_load, dp_final, dp_round, dp_rcon, user_interrupt);
    end
    bus_read(A_STATUS, d, rdy);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL rst_status: got %h, expected 00000000", d);
    end
    bus_read(A_CTRL, d, rdy);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL rst_irq_en: got %h, expected 00000000", d);
    end
    bus_write(A_CTRL, 32'h3);
    wait_irq(1, cnt);
    checks++;
    if (cnt !== 12) begin
      failures++;
      $display("FAIL rst_rerun_latency: got completion at T+%0d, expected T+12", cnt);
    end
  endtask

  initial begin
    rst          = 1'b1;
    address      = 6'd0;
    data_in      = 32'd0;
    data_write_n = 2'b11;
    data_read_n  = 2'b11;
    dp_ready     = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    test_reset();
    test_word_write();
    test_full_run();
    test_ready_stall();
    test_res_read_stall();
    test_busy_writes();
    test_irq();
    test_rst_mid_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
